// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared state encoding and counter sizing for the key conditioner
package key_cond_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } key_state_t;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: sync + debounce FSM + press pulse for one key; KEY_AUTOREPEAT_EN adds a held-key repeat train
module key_debounce_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic pulse
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_debounce_channel: cycle parameters must be >= 1");
    end
    logic [1:0]    r_sync;
    key_state_t    r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          w_s, w_press_pulse, w_rep_hit;
    assign w_s = ~r_sync[1];
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_press_pulse = 1'b0;
        case (r_state)
            S_IDLE:
                if (w_s) begin
                    w_state_n = S_PRESS_WAIT;
                    w_cnt_n   = CW'(1);
                end
            S_PRESS_WAIT:
                if (!w_s) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end else if (r_cnt == DB_MAX) begin
                    w_state_n     = S_HELD;
                    w_press_pulse = 1'b1;
                end else w_cnt_n = r_cnt + 1'b1;
            S_HELD:
                if (!w_s) begin
                    w_state_n = S_RELEASE_WAIT;
                    w_cnt_n   = CW'(1);
                end
            default:
                if (w_s) w_state_n = S_HELD;
                else if (r_cnt == DB_MAX) w_state_n = S_IDLE;
                else w_cnt_n = r_cnt + 1'b1;
        endcase
    end
`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    logic [RW-1:0] r_rep, w_lim;
    logic          r_armed, w_stay;
    assign w_stay    = (r_state == S_HELD) && (w_state_n == S_HELD);
    assign w_lim     = r_armed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign w_rep_hit = w_stay && (r_rep == w_lim);
    // Cleared on leaving S_HELD, so a bounce back from release restarts the full delay
    always_ff @(posedge clk) begin
        if (reset || (r_state == S_HELD && !w_stay)) begin
            r_rep   <= '0;
            r_armed <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep   <= '0;
            r_armed <= 1'b1;
        end else if (w_stay) r_rep <= r_rep + 1'b1;
    end
`else
    assign w_rep_hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            pressed <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            pressed <= (w_state_n == S_HELD) || (w_state_n == S_RELEASE_WAIT);
            pulse   <= w_press_pulse || w_rep_hit;
        end
    end
endmodule

// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: NUM_KEYS independent debounced key channels (auto-repeat via KEY_AUTOREPEAT_EN)
module key_pulse_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] pulse
);
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .key_n  (key_n[g]),
            .pressed(pressed[g]),
            .pulse  (pulse[g])
        );
    end
endmodule
